// File: rtl/muldiv_seq_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer.
package pipes;

    // One iteration per result bit for RV64.
    localparam int MULDIV_ITERS = 64;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } muldiv_op_t;

    // Decode bundle carried down the pipe; only the muldiv fields live here.
    typedef struct packed {
        logic       muldiv;
        muldiv_op_t muldivop;
    } control_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } muldiv_state_t;

    function automatic logic is_w_op(input muldiv_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                          OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: shift-add multiply step and restoring divide step.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic [XLEN-1:0]   mplier,
    input  logic              msub,
    input  logic [XLEN-1:0]   rem,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   dsr,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [2*XLEN-1:0] mcand_nxt,
    output logic [XLEN-1:0]   mplier_nxt,
    output logic [XLEN-1:0]   rem_nxt,
    output logic [XLEN-1:0]   quo_nxt
);

    logic [2*XLEN-1:0] addend;
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;

    // Multiply: msub subtracts on the sign bit of a signed multiplier, which
    // gives its two's-complement weight without a separate fix-up pass.
    // Divide: trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        addend     = mplier[0] ? mcand : '0;
        acc_nxt    = msub ? (acc - addend) : (acc + addend);
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;

        shifted = {rem, quo[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, dsr};
        if (diff[XLEN+1]) begin
            rem_nxt = shifted[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV64M multi-cycle multiply/divide sequencer for the execute stage.
module muldiv_seq
    import pipes::*;
#(
    parameter int XLEN          = MULDIV_ITERS,
    parameter bit ZERO_SHORTCUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q;
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q, rem_q, quo_q, dsr_q, result_q;
    logic [CW-1:0]     cnt_q;
    logic              msub_q, qneg_q, rneg_q;

    logic              accept, iterate, last, load_result;
    logic [XLEN-1:0]   res_d;

    logic              w_op, div_op, div_signed, w_signed, b_zero, a_neg, b_neg;
    logic [XLEN-1:0]   a_x, b_x, mag_a, mag_b;
    logic [2*XLEN-1:0] a_ext;

    logic [2*XLEN-1:0] acc_nxt, mcand_nxt;
    logic [XLEN-1:0]   mplier_nxt, rem_nxt, quo_nxt;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] x);
        return {{(XLEN-32){1'b0}}, x[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] finish_mul(input muldiv_op_t o,
                                                   input logic [2*XLEN-1:0] prod);
        case (o)
            OP_MUL:  return prod[XLEN-1:0];
            OP_MULW: return sext32(prod[XLEN-1:0]);
            default: return prod[2*XLEN-1:XLEN];
        endcase
    endfunction

    function automatic logic [XLEN-1:0] finish_div(input muldiv_op_t o,
                                                   input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] r,
                                                   input logic qneg,
                                                   input logic rneg);
        logic [XLEN-1:0] qf, rf;
        qf = qneg ? (-q) : q;
        rf = rneg ? (-r) : r;
        case (o)
            OP_REM, OP_REMU:   return rf;
            OP_DIVW, OP_DIVUW: return sext32(qf);
            OP_REMW, OP_REMUW: return sext32(rf);
            default:           return qf;
        endcase
    endfunction

    // Operand preparation from the live execute inputs, used only at accept.
    always_comb begin
        w_op       = is_w_op(op);
        div_op     = is_div_op(op);
        div_signed = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        w_signed   = op inside {OP_MULW, OP_DIVW, OP_REMW};
        a_x        = w_op ? (w_signed ? sext32(src1) : zext32(src1)) : src1;
        b_x        = w_op ? (w_signed ? sext32(src2) : zext32(src2)) : src2;
        b_zero     = (b_x == '0);
        a_neg      = div_signed & a_x[XLEN-1];
        b_neg      = div_signed & b_x[XLEN-1];
        mag_a      = a_neg ? (-a_x) : a_x;
        mag_b      = b_neg ? (-b_x) : b_x;
        a_ext      = (op == OP_MULH || op == OP_MULHSU) ? {{XLEN{a_x[XLEN-1]}}, a_x}
                                                        : {{XLEN{1'b0}}, a_x};
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .msub       (msub_q & last),
        .rem        (rem_q),
        .quo        (quo_q),
        .dsr        (dsr_q),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt),
        .rem_nxt    (rem_nxt),
        .quo_nxt    (quo_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, control strobes and the value to capture on entry to FIN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        iterate = 1'b0;
        last    = (cnt_q == CW'(XLEN-1));
        res_d   = result_q;
        case (state_q)
            ST_IDLE: begin
                res_d = finish_div(op, '1, a_x, 1'b0, 1'b0);
                if (valid && !flush) begin
                    accept = 1'b1;
                    if (!div_op)                   state_d = ST_MUL;
                    else if (ZERO_SHORTCUT && b_zero) state_d = ST_FIN;
                    else                           state_d = ST_DIV;
                end
            end
            ST_MUL: begin
                iterate = 1'b1;
                res_d   = finish_mul(op_q, acc_nxt);
                if (last) state_d = ST_FIN;
            end
            ST_DIV: begin
                iterate = 1'b1;
                res_d   = finish_div(op_q, quo_nxt, rem_nxt, qneg_q, rneg_q);
                if (last) state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
        load_result = (state_d == ST_FIN) && (state_q != ST_FIN);
    end

    // Working registers: loaded at accept, advanced once per iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            msub_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= op;
                acc_q    <= '0;
                mcand_q  <= a_ext;
                mplier_q <= b_x;
                msub_q   <= (op == OP_MULH);
                rem_q    <= '0;
                quo_q    <= mag_a;
                dsr_q    <= mag_b;
                qneg_q   <= (a_neg ^ b_neg) & ~b_zero;
                rneg_q   <= a_neg;
                cnt_q    <= '0;
            end else if (iterate) begin
                acc_q    <= acc_nxt;
                mcand_q  <= mcand_nxt;
                mplier_q <= mplier_nxt;
                rem_q    <= rem_nxt;
                quo_q    <= quo_nxt;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (load_result) result_q <= res_d;
        end
    end

    assign done   = (state_q == ST_FIN);
    assign busy   = (state_q != ST_IDLE);
    assign stall  = valid & ~done;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq; a second instance covers ZERO_SHORTCUT=0.
module tb_muldiv_seq;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset, valid, flush, sel;
    muldiv_op_t  op;
    logic [63:0] src1, src2;

    logic        valid0, valid1, flush0, flush1;
    logic        stall0, done0, busy0, stall1, done1, busy1;
    logic [63:0] result0, result1;
    logic        stall, done, busy;
    logic [63:0] result;

    int total  = 0;
    int passed = 0;

    assign valid0 = valid & ~sel;
    assign valid1 = valid & sel;
    assign flush0 = flush & ~sel;
    assign flush1 = flush & sel;
    assign stall  = sel ? stall1  : stall0;
    assign done   = sel ? done1   : done0;
    assign busy   = sel ? busy1   : busy0;
    assign result = sel ? result1 : result0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(64), .ZERO_SHORTCUT(1'b1)) dut (
        .clk(clk), .reset(reset), .valid(valid0), .op(op), .src1(src1), .src2(src2),
        .flush(flush0), .stall(stall0), .done(done0), .result(result0), .busy(busy0)
    );

    muldiv_seq #(.XLEN(64), .ZERO_SHORTCUT(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .valid(valid1), .op(op), .src1(src1), .src2(src2),
        .flush(flush1), .stall(stall1), .done(done1), .result(result1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a rising edge; that cycle is the accept cycle t.
    task automatic run_op(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] e, input int lat, input string tag);
        int   n;
        logic stall_ok;
        op = o; src1 = a; src2 = b; valid = 1'b1;
        n = 0;
        #1;
        stall_ok = (stall === 1'b1);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, result, e);
        chk({tag, " stall_low_at_done"}, {63'd0, stall}, 64'd0);
        chk({tag, " stall_high_while_busy"}, {63'd0, stall_ok}, 64'd1);
        valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
        chk({tag, " idle_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic saw_done;
        reset = 1'b1; valid = 1'b0; flush = 1'b0; sel = 1'b0;
        op = OP_MUL; src1 = '0; src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset done",   {63'd0, done0},  64'd0);
        chk("reset busy",   {63'd0, busy0},  64'd0);
        chk("reset result", result0,         64'd0);
        chk("reset stall",  {63'd0, stall0}, 64'd0);
        chk("reset busy nz", {63'd0, busy1}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(OP_MUL,    64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul 7*-3");
        run_op(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 65, "mulhu");
        run_op(OP_MULH,   -64'sd1, -64'sd1, 64'h0, 65, "mulh -1*-1");
        run_op(OP_MULHSU, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu -1*2");
        run_op(OP_DIV,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div -7/2");
        run_op(OP_REM,    -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem -7/2");
        run_op(OP_DIV,    64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 65, "div ovf");
        run_op(OP_REM,    64'h8000_0000_0000_0000, -64'sd1, 64'h0, 65, "rem ovf");
        run_op(OP_DIVU,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu by0 short");
        run_op(OP_REMU,   64'd5, 64'd0, 64'd5, 1, "remu by0 short");

        sel = 1'b1;
        run_op(OP_DIVU,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 65, "divu by0 iter");
        run_op(OP_REMU,   64'd5, 64'd0, 64'd5, 65, "remu by0 iter");
        run_op(OP_REM,    -64'sd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7, 65, "rem -9/0 iter");
        sel = 1'b0;

        run_op(OP_DIVW,   64'hDEAD_0000_8000_0000, -64'sd1, 64'hFFFF_FFFF_8000_0000, 65, "divw ovf");
        run_op(OP_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulw");

        // flush together with valid in IDLE must not accept
        op = OP_DIV; src1 = 64'd100; src2 = 64'd7; valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush blocks accept", {63'd0, busy}, 64'd0);
        valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1;

        // flush in cycle t+30 of a DIV
        saw_done = 1'b0;
        op = OP_DIV; src1 = 64'd100; src2 = 64'd7; valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("flush busy before", {63'd0, busy}, 64'd1);
        flush = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush idle at t+31", {63'd0, busy}, 64'd0);
        chk("flush result kept", result, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("flush no done", {63'd0, saw_done}, 64'd0);
        run_op(OP_MUL, 64'd123, 64'd456, 64'd56088, 65, "mul after flush");

        // reset at t+10 of a MUL
        op = OP_MUL; src1 = 64'd3; src2 = 64'd5; valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midop busy", {63'd0, busy}, 64'd1);
        reset = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        chk("midreset done",   {63'd0, done},  64'd0);
        chk("midreset busy",   {63'd0, busy},  64'd0);
        chk("midreset result", result,         64'd0);
        chk("midreset stall",  {63'd0, stall}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(OP_DIVU,  64'd100, 64'd7, 64'd14, 65, "divu after reset");
        run_op(OP_REMUW, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd2, 65, "remuw");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
